// File: rtl/pool_pkg.sv
// Shared pooling definitions: controller state encoding and default geometry.
// Imported by the IFM loader and the pooling controller.
package pool_pkg;

    localparam int unsigned POOL_IFM_SIZE = 9;
    localparam int unsigned POOL_CI       = 3;
    localparam int unsigned POOL_DATA_W   = 16;

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StFetch = 2'b01;
    localparam logic [1:0] StFull  = 2'b10;
    localparam logic [1:0] StDone  = 2'b11;

    // Bits needed to hold every value 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pool_ifm_loader_if.sv
// Memory-read and consumer-pop signals of the IFM loader.
// master = loader side, slave = memory/consumer side.
interface pool_ifm_loader_if
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W = POOL_DATA_W,
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              ifm_read;
    logic              full;
    logic [DATA_W-1:0] ifm_data;
    logic              ifm_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, mem_rdata, ifm_read,
        output mem_req, mem_addr, full, ifm_data, ifm_valid, busy, done
    );

    modport slave (
        output start, mem_rdata, ifm_read,
        input  mem_req, mem_addr, full, ifm_data, ifm_valid, busy, done
    );
endinterface

// File: rtl/pool_row_buf.sv
// One-row pixel buffer: synchronous write port, registered read port.
// Storage is not reset; only the read register is.
module pool_row_buf #(
    parameter int unsigned DEPTH  = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Holds the last popped pixel while no read is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/pool_ifm_loader.sv
// Streams an IFM (CI channels of IFM_SIZE rows) from memory one row at a time
// through a row buffer that the consumer drains with ifm_read pops.
module pool_ifm_loader
    import pool_pkg::*;
#(
    parameter int unsigned       IFM_SIZE  = POOL_IFM_SIZE,
    parameter int unsigned       CI        = POOL_CI,
    parameter int unsigned       DATA_W    = POOL_DATA_W,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic               clk1,
    input logic               rst,
    pool_ifm_loader_if.master bus
);
    localparam int unsigned      IdxW    = cnt_width(IFM_SIZE);
    localparam int unsigned      ChW     = cnt_width(CI);
    localparam logic [IdxW-1:0]  RowLen  = IdxW'(IFM_SIZE);
    localparam logic [IdxW-1:0]  RowLast = IdxW'(IFM_SIZE - 1);
    localparam logic [ChW-1:0]   ChLast  = ChW'(CI - 1);

    logic [1:0]        state_q, state_d;
    logic [IdxW-1:0]   req_cnt_q, req_cnt_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0]   line_q, line_d;
    logic [ChW-1:0]    chan_q, chan_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rsp_vld_q, full_q, valid_q;
    logic              req, pop, last_wr, last_pop;
    logic [DATA_W-1:0] buf_rdata;

    assign req      = (state_q == StFetch) && (req_cnt_q < RowLen);
    assign pop      = (state_q == StFull) && bus.ifm_read;
    assign last_wr  = rsp_vld_q && (wr_idx_q == RowLast);
    assign last_pop = pop && (rd_ptr_q == RowLast);

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        wr_idx_d  = wr_idx_q;
        rd_ptr_d  = rd_ptr_q;
        line_d    = line_q;
        chan_d    = chan_q;
        addr_d    = addr_q;
        case (state_q)
            StIdle: begin
                line_d = '0;
                chan_d = '0;
                addr_d = BASE_ADDR;
                if (bus.start) state_d = StFetch;
            end
            StFetch: begin
                if (req) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                    addr_d    = addr_q + 1'b1;
                end
                if (rsp_vld_q) wr_idx_d = wr_idx_q + 1'b1;
                if (last_wr) state_d = StFull;
            end
            StFull: begin
                if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
                if (last_pop) begin
                    if (line_q < RowLast) begin
                        line_d  = line_q + 1'b1;
                        state_d = StFetch;
                    end else if (chan_q < ChLast) begin
                        line_d  = '0;
                        chan_d  = chan_q + 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Every entry into FETCH starts a fresh row transfer.
        if (state_d == StFetch && state_q != StFetch) begin
            req_cnt_d = '0;
            wr_idx_d  = '0;
            rd_ptr_d  = '0;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q   <= StIdle;
            req_cnt_q <= '0;
            wr_idx_q  <= '0;
            rd_ptr_q  <= '0;
            line_q    <= '0;
            chan_q    <= '0;
            addr_q    <= BASE_ADDR;
            rsp_vld_q <= 1'b0;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            wr_idx_q  <= wr_idx_d;
            rd_ptr_q  <= rd_ptr_d;
            line_q    <= line_d;
            chan_q    <= chan_d;
            addr_q    <= addr_d;
            rsp_vld_q <= req;
            full_q    <= (state_d == StFull);
            valid_q   <= pop;
        end
    end

    pool_row_buf #(
        .DEPTH  (IFM_SIZE),
        .DATA_W (DATA_W),
        .IDX_W  (IdxW)
    ) u_row_buf (
        .clk_i   (clk1),
        .rst_i   (rst),
        .we_i    (rsp_vld_q),
        .waddr_i (wr_idx_q),
        .wdata_i (bus.mem_rdata),
        .re_i    (pop),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    assign bus.mem_req   = req;
    assign bus.mem_addr  = addr_q;
    assign bus.full      = full_q;
    assign bus.ifm_data  = buf_rdata;
    assign bus.ifm_valid = valid_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
endmodule

// File: tb/tb_pool_ifm_loader.sv
// Bench for pool_ifm_loader: scenario table, hand sequences and random traffic,
// all checked cycle by cycle against a row/pop-count reference model.
module tb_pool_ifm_loader;
    localparam int              N     = 9;
    localparam int              C     = 3;
    localparam int              DW    = 16;
    localparam int              AW    = 16;
    localparam logic [AW-1:0]   BASE  = 16'h100;
    localparam int              TOTAL = N * N * C;

    typedef struct {
        string name;
        int    on;
        int    off;
        bit    spurious;
        bit    busy_start;
        int    exp_pops;
        int    exp_eps;
        int    exp_dones;
    } vec_t;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    pool_ifm_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    pool_ifm_loader #(
        .IFM_SIZE  (N),
        .CI        (C),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    // Memory returns data = address, one cycle after the request.
    always @(posedge clk1) bus.mem_rdata <= bus.mem_addr;

    int total = 0;
    int bad   = 0;
    int n_pops, n_dones, n_eps;
    bit prev_full = 1'b0;

    // Reference model: phase counters in terms of row fetch length and pop count.
    bit            m_busy = 0, m_full = 0, m_done = 0, m_valid = 0;
    int            m_k = -1;
    int            m_popcnt = 0;
    logic [AW-1:0] m_addr = BASE;
    logic [DW-1:0] m_data = '0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit rd);
        bit o_busy = m_busy, o_full = m_full, o_done = m_done;
        int o_k = m_k;
        m_valid = 0;
        m_done  = 0;
        if (r) begin
            m_busy = 0; m_full = 0; m_k = -1; m_data = '0; m_popcnt = 0;
            return;
        end
        if (o_done) begin
            m_busy = 0;
        end else if (!o_busy) begin
            if (s) begin
                m_busy = 1; m_k = 0; m_addr = BASE; m_popcnt = 0;
            end
        end else if (o_k >= 0) begin
            if (o_k < N) m_addr = m_addr + 1'b1;
            if (o_k == N) begin
                m_k = -1; m_full = 1;
            end else begin
                m_k = o_k + 1;
            end
        end else if (o_full && rd) begin
            m_valid = 1;
            m_data  = DW'(int'(BASE) + m_popcnt);
            m_popcnt++;
            if (m_popcnt % N == 0) begin
                m_full = 0;
                if (m_popcnt == TOTAL) m_done = 1;
                else m_k = 0;
            end
        end
    endfunction

    function automatic void check_outputs();
        bit ereq = (m_k >= 0) && (m_k < N);
        chk("mem_req", bus.mem_req, ereq);
        if (ereq) chk("mem_addr", bus.mem_addr, m_addr);
        chk("full", bus.full, m_full);
        chk("ifm_valid", bus.ifm_valid, m_valid);
        chk("ifm_data", bus.ifm_data, m_data);
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
    endfunction

    task automatic tick(input bit r, input bit s, input bit rd);
        rst          = r;
        bus.start    = s;
        bus.ifm_read = rd;
        @(posedge clk1);
        model_step(r, s, rd);
        @(negedge clk1);
        check_outputs();
        if (bus.ifm_valid) n_pops++;
        if (bus.done) n_dones++;
        if (bus.full && !prev_full) n_eps++;
        prev_full = bus.full;
    endtask

    task automatic run_load(input vec_t v);
        int c = 0;
        bit rd, s;
        n_pops = 0; n_dones = 0; n_eps = 0;
        tick(0, 1, v.spurious);
        while (n_dones == 0 && c < 4000) begin
            rd = v.spurious ? 1'b1 : (bus.full && ((c % (v.on + v.off)) < v.on));
            s  = v.busy_start && bus.full;
            tick(0, s, rd);
            c++;
        end
        if (c >= 4000) chk({v.name, "_timeout"}, c, 0);
        repeat (3) tick(0, 0, v.spurious);
        chk({v.name, "_pops"}, n_pops, v.exp_pops);
        chk({v.name, "_episodes"}, n_eps, v.exp_eps);
        chk({v.name, "_dones"}, n_dones, v.exp_dones);
    endtask

    initial begin
        vec_t vecs[4];
        bit   req_seen[12], full_seen[12];
        logic [AW-1:0] addr_seen[12];
        int   c;

        vecs[0] = '{name: "basic",   on: 1, off: 0, spurious: 0, busy_start: 0,
                    exp_pops: TOTAL, exp_eps: N * C, exp_dones: 1};
        vecs[1] = '{name: "stalled", on: 1, off: 3, spurious: 0, busy_start: 0,
                    exp_pops: TOTAL, exp_eps: N * C, exp_dones: 1};
        vecs[2] = '{name: "spurious", on: 1, off: 0, spurious: 1, busy_start: 0,
                    exp_pops: TOTAL, exp_eps: N * C, exp_dones: 1};
        vecs[3] = '{name: "busystart", on: 1, off: 0, spurious: 0, busy_start: 1,
                    exp_pops: TOTAL, exp_eps: N * C, exp_dones: 1};

        bus.start = 1'b0;
        bus.ifm_read = 1'b0;

        // Reset state
        tick(1, 0, 0);
        tick(1, 1, 1);
        chk("reset_mem_addr", bus.mem_addr, BASE);
        tick(0, 0, 0);

        // First fetch timing relative to the start cycle t
        tick(0, 1, 0);
        req_seen[0] = bus.mem_req; full_seen[0] = bus.full; addr_seen[0] = bus.mem_addr;
        for (int i = 1; i < 12; i++) begin
            tick(0, 0, 0);
            req_seen[i] = bus.mem_req; full_seen[i] = bus.full; addr_seen[i] = bus.mem_addr;
        end
        // Index i holds cycle t+1+i.
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("t%0d_req", i + 1), req_seen[i], (i < N));
            chk($sformatf("t%0d_full", i + 1), full_seen[i], (i == N + 1));
        end
        chk("t1_addr", addr_seen[0], BASE);
        chk("t9_addr", addr_seen[8], BASE + 16'd8);
        tick(1, 0, 0);
        tick(0, 0, 0);

        for (int v = 0; v < 4; v++) run_load(vecs[v]);

        // Mid-load reset in row 5 of channel 1, then restart from scratch
        n_dones = 0;
        tick(0, 1, 0);
        c = 0;
        while (m_popcnt < (N + 5) * N + 3 && c < 3000) begin
            tick(0, 0, bus.full);
            c++;
        end
        if (c >= 3000) chk("midreset_timeout", c, 0);
        tick(1, 0, 1);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ifm_valid", bus.ifm_valid, 0);
        chk("rst_ifm_data", bus.ifm_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mem_addr", bus.mem_addr, BASE);
        repeat (5) tick(0, 0, 1);
        chk("midreset_no_done", n_dones, 0);
        n_pops = 0;
        tick(0, 1, 0);
        chk("restart_req", bus.mem_req, 1);
        chk("restart_addr", bus.mem_addr, BASE);
        c = 0;
        while (n_dones == 0 && c < 4000) begin
            tick(0, 0, bus.full);
            c++;
        end
        chk("restart_pops", n_pops, TOTAL);
        chk("restart_dones", n_dones, 1);

        // Random traffic: random consumer, start pulses and occasional resets
        for (int l = 0; l < 3; l++) begin
            repeat (900) begin
                tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 3) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pool_ifm_loader.md
POOL_IFM_LOADER -- requirements
Module: pool_ifm_loader

Interface
REQ-001 Parameters SHALL be: IFM_SIZE, default 9, row length and rows per channel; CI, default 3, channel count; DATA_W, default 16, pixel width; ADDR_W, default 16, memory address width; BASE_ADDR, default 0, address of first pixel.
REQ-002 Ports SHALL be, clock and reset first:
- clk1  in  1  only clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins one full IFM load.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_req.
- ifm_read  in  1  consumer pop strobe.
- full  out  1  row buffer holds a complete row.
- ifm_data  out  DATA_W  popped pixel.
- ifm_valid  out  1  ifm_data is valid.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse after the last row is drained.

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, FULL and DONE.
REQ-004 IDLE SHALL move to FETCH on start. In IDLE, cnt_line and cnt_channel SHALL be cleared and the address pointer SHALL be set to BASE_ADDR.
REQ-005 In FETCH, mem_req SHALL be 1 for exactly IFM_SIZE consecutive cycles, with mem_addr incrementing by 1 each cycle. Addresses SHALL be contiguous across rows and channels.
REQ-006 The data returned one cycle after each request SHALL be written to the row buffer (IFM_SIZE x DATA_W) at the index of its request, 0..IFM_SIZE-1.
REQ-007 FETCH SHALL move to FULL on the cycle after the last response is written. full SHALL be registered and SHALL equal 1 throughout FULL and only in FULL.
REQ-008 In FULL, each ifm_read SHALL pop buffer[rd_ptr] onto ifm_data with ifm_valid=1 on the next cycle, then increment rd_ptr.
REQ-009 When ifm_read is 0, ifm_valid SHALL be 0 on the next cycle and ifm_data SHALL hold its value.
REQ-010 ifm_read outside FULL SHALL be ignored and SHALL NOT change any counter.
REQ-011 On the IFM_SIZE-th pop, the FSM SHALL leave FULL on the next edge, so full drops the cycle after the last ifm_read.
REQ-012 Row sequencing on leaving FULL:
- cnt_line < IFM_SIZE-1: increment cnt_line, go to FETCH.
- cnt_line == IFM_SIZE-1 and cnt_channel < CI-1: clear cnt_line, increment cnt_channel, go to FETCH.
- otherwise: go to DONE.
REQ-013 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-014 busy SHALL be 1 in FETCH, FULL and DONE, and 0 in IDLE.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 Counters SHALL be wide enough for IFM_SIZE, CI and IFM_SIZE*IFM_SIZE*CI without wrap. mem_addr SHALL wrap modulo 2^ADDR_W.
REQ-017 The rd_ptr and write-index counters SHALL be cleared on every entry to FETCH.

Reset
REQ-018 While rst=1 at a clk1 edge, the FSM SHALL go to IDLE and all counters SHALL be cleared.
REQ-019 While rst=1 at a clk1 edge, these outputs SHALL be 0: mem_req, full, ifm_valid, ifm_data, busy, done.
REQ-020 mem_addr SHALL be BASE_ADDR during reset.
REQ-021 Reset asserted mid-load SHALL abort the load without a done pulse.
REQ-022 Any response in flight when reset is asserted SHALL be discarded.
REQ-023 Row buffer contents need no reset.

Structure
REQ-024 A shared pool package SHALL hold the state encodings (IDLE=2'b00, FETCH=2'b01, FULL=2'b10, DONE=2'b11) and the default values of IFM_SIZE, CI and DATA_W, shared with the pooling controller.
REQ-025 The row buffer SHALL be a separate sub-module named pool_row_buf, with one synchronous write port and one synchronous read port.
REQ-026 Next-state logic SHALL be a complete combinational case on the current state with a default to IDLE.

Verification
REQ-027 The bench SHALL run these scenarios with IFM_SIZE=9, CI=3, BASE_ADDR=0x100, and memory returning data = address:
- Basic load: start, then continuous ifm_read whenever full=1 -> exactly 27 full episodes, 243 pops, ifm_data sequence 0x100..0x1F2, then one done pulse.
- First fetch timing: start at cycle t -> mem_req high cycles t+1..t+9 with mem_addr 0x100..0x108, and full=1 at t+11.
- Stalled consumer: after full, ifm_read gapped 1-on/3-off -> no pop lost or duplicated, and full stays 1 until the 9th pop.
- Spurious strobes: ifm_read held high during FETCH and IDLE -> ifm_valid stays 0 and the output sequence is unchanged.
- Mid-load reset: rst asserted in row 5 of channel 1 -> all outputs 0 next cycle, no done; a fresh start restarts at 0x100.
- Busy start: start pulsed during FULL -> ignored, and total pops remain 243.
